// File: rtl/dmem_word_reader.sv
// Read-back engine for the byte-wide data memory: walks a word-aligned range,
// reads four bytes per word and streams little-endian words on a valid/ready port.
module dmem_word_reader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [31:0]       word_data,
  output logic [ADDR_W-1:0] word_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] base_r;
  logic [CNT_W-1:0]  remaining_r;
  logic [1:0]        issue_idx_r;
  logic              pend_v_r;
  logic [1:0]        pend_idx_r;
  logic [ADDR_W-1:0] aligned_s;
  logic [ADDR_W-1:0] next_base_s;

  assign aligned_s   = start_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
  assign next_base_s = base_r + ADDR_W'(4);

  // Sequencer, byte-capture pipeline and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      base_r      <= '0;
      remaining_r <= '0;
      issue_idx_r <= 2'd0;
      pend_v_r    <= 1'b0;
      pend_idx_r  <= 2'd0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      word_valid  <= 1'b0;
      word_data   <= 32'd0;
      word_addr   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // A byte requested in one cycle is on mem_rdata during the next one.
      pend_v_r   <= mem_rd_en;
      pend_idx_r <= issue_idx_r;
      if (pend_v_r) begin
        case (pend_idx_r)
          2'd0:    word_data[7:0]   <= mem_rdata;
          2'd1:    word_data[15:8]  <= mem_rdata;
          2'd2:    word_data[23:16] <= mem_rdata;
          default: word_data[31:24] <= mem_rdata;
        endcase
      end
      done <= 1'b0;

      case (state_r)
        IDLE: begin
          if (start) begin
            base_r      <= aligned_s;
            remaining_r <= num_words;
            busy        <= 1'b1;
            if (num_words == CNT_W'(0)) begin
              state_r <= FIN;
            end else begin
              state_r     <= ISSUE;
              mem_rd_en   <= 1'b1;
              mem_addr    <= aligned_s;
              issue_idx_r <= 2'd0;
            end
          end
        end
        ISSUE: begin
          if (issue_idx_r == 2'd3) begin
            state_r   <= DRAIN;
            mem_rd_en <= 1'b0;
          end else begin
            issue_idx_r <= issue_idx_r + 2'd1;
            mem_addr    <= mem_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          state_r    <= OUT;
          word_valid <= 1'b1;
          word_addr  <= base_r;
        end
        OUT: begin
          if (word_ready) begin
            word_valid  <= 1'b0;
            remaining_r <= remaining_r - CNT_W'(1);
            base_r      <= next_base_s;
            if (remaining_r == CNT_W'(1)) begin
              state_r <= FIN;
            end else begin
              state_r     <= ISSUE;
              mem_rd_en   <= 1'b1;
              mem_addr    <= next_base_s;
              issue_idx_r <= 2'd0;
            end
          end
        end
        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          mem_rd_en  <= 1'b0;
          word_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_word_reader.sv
// Bench for dmem_word_reader: table of dump scenarios driven against a byte
// memory model, with a scoreboard of expected words and read addresses.
module tb_dmem_word_reader;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  num_words;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              word_valid;
  logic              word_ready;
  logic [31:0]       word_data;
  logic [ADDR_W-1:0] word_addr;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  dmem_word_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .num_words(num_words), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .word_addr(word_addr), .busy(busy), .done(done)
  );

  logic [7:0] dm [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= dm[mem_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int words_seen = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } word_t;
  word_t      exp_q[$];
  logic [7:0] addr_q[$];

  typedef struct {
    logic        fill;
    logic [7:0]  addr;
    logic [7:0]  n;
    int          stall;
    logic [31:0] w0;
    logic [7:0]  a0;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: read addresses, accepted words and done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd_en) begin
        rd_cnt++;
        if (addr_q.size() > 0) check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (word_valid && word_ready) begin
        words_seen++;
        if (exp_q.size() > 0) begin
          word_t w;
          w = exp_q.pop_front();
          check("word_addr", 32'(word_addr), 32'(w.a));
          check("word_data", word_data, w.d);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic load_mem(input logic fill);
    for (int i = 0; i < 256; i++) dm[i] = 8'(i);
    if (fill) begin
      dm[0] = 8'hF8; dm[1] = 8'hFF; dm[2] = 8'hFF; dm[3] = 8'hFF;
    end
  endtask

  task automatic expect_dump(input logic [7:0] addr, input int n);
    logic [7:0] a;
    word_t w;
    for (int i = 0; i < n; i++) begin
      a = (addr & 8'hFC) + 8'(4 * i);
      w.a = a;
      w.d = {dm[a + 8'd3], dm[a + 8'd2], dm[a + 8'd1], dm[a]};
      exp_q.push_back(w);
      for (int k = 0; k < 4; k++) addr_q.push_back(a + 8'(k));
    end
  endtask

  task automatic run_dump(input vec_t v);
    int t0, last, waited;
    logic [31:0] hold_d;
    logic [7:0]  hold_a;
    logic ok;
    load_mem(v.fill);
    rd_cnt = 0; done_cnt = 0; words_seen = 0;
    exp_q.delete(); addr_q.delete();
    expect_dump(v.addr, int'(v.n));
    word_ready = (v.stall == 0);
    @(posedge clk); #1;
    start = 1'b1; start_addr = v.addr; num_words = v.n;
    @(posedge clk); #1;
    t0 = cyc;
    // Second start with junk operands lands while busy (or in FIN when n=0).
    start_addr = 8'h55; num_words = 8'd9;
    @(negedge clk);
    check("busy_after_start", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    last = t0;
    ok = 1'b1;
    for (int w = 0; w < int'(v.n) && ok; w++) begin
      waited = 0;
      @(negedge clk);
      while (!word_valid && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      if (!word_valid) begin
        check("valid_timeout", 32'(word_valid), 32'd1);
        ok = 1'b0;
      end else begin
        if (w == 0) begin
          check("first_latency", 32'(cyc - last + 1), 32'd6);
          check("w0_data", word_data, v.w0);
          check("w0_addr", 32'(word_addr), 32'(v.a0));
        end else begin
          check("next_latency", 32'(cyc - last), 32'd5);
        end
        if (v.stall > 0) begin
          hold_d = word_data;
          hold_a = word_addr;
          for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(word_valid), 32'd1);
            check("stall_data", word_data, hold_d);
            check("stall_addr", 32'(word_addr), 32'(hold_a));
          end
          @(posedge clk); #1 word_ready = 1'b1;
          @(posedge clk); #1 word_ready = 1'b0;
        end else begin
          @(posedge clk); #1;
        end
        last = cyc;
      end
    end
    waited = 0;
    @(negedge clk);
    while (!done && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_gap", 32'(cyc - last), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    word_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("done_count", 32'(done_cnt), 32'd1);
    check("word_count", 32'(words_seen), 32'(v.n));
    check("rd_count", 32'(rd_cnt), 32'(4 * int'(v.n)));
    check("queue_empty", 32'(exp_q.size() + addr_q.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_valid"}, 32'(word_valid), 32'd0);
    check({tag, "_data"}, word_data, 32'd0);
    check({tag, "_waddr"}, 32'(word_addr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int waited;
    vec_t v;
    //          fill  addr   n      stall w0              a0
    tbl[0] = '{1'b1, 8'h00, 8'd1, 0,  32'hFFFF_FFF8, 8'h00};
    tbl[1] = '{1'b0, 8'h00, 8'd4, 0,  32'h0302_0100, 8'h00};
    tbl[2] = '{1'b0, 8'h00, 8'd4, 10, 32'h0302_0100, 8'h00};
    tbl[3] = '{1'b0, 8'hFE, 8'd2, 0,  32'hFFFE_FDFC, 8'hFC};
    tbl[4] = '{1'b0, 8'h10, 8'd0, 0,  32'h0000_0000, 8'h00};
    tbl[5] = '{1'b0, 8'h33, 8'd3, 2,  32'h3332_3130, 8'h30};

    reset = 1'b1; start = 1'b0; start_addr = 8'd0; num_words = 8'd0; word_ready = 1'b0;
    load_mem(1'b0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_dump(tbl[i]);

    // Reset while word 2 of a 3-word dump is being issued.
    load_mem(1'b0);
    rd_cnt = 0; done_cnt = 0; words_seen = 0;
    exp_q.delete(); addr_q.delete();
    expect_dump(8'h20, 3);
    word_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 8'h20; num_words = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (words_seen < 2 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check("abort_two_words", 32'(words_seen), 32'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_issue", 32'(mem_rd_en), 32'd1);
    reset = 1'b1;
    #1;
    check_outputs_zero("abort");
    word_ready = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete(); addr_q.delete();
    done_cnt = 0;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    v = '{1'b0, 8'h40, 8'd1, 0, 32'h4342_4140, 8'h40};
    run_dump(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
